sop_et_sweep_ctrl: RTL



---
 rtl/sop_et_sweep_ctrl.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/sop_et_sweep_ctrl.sv
// sop_et_sweep_ctrl: exhaustive error sweep of a runtime-configured shared-product SOP
// against the exact |a-b| function, reporting max error, error count and pass/fail.
`default_nettype none

module sop_et_sweep_ctrl #(
    parameter int N_IN   = 4,
    parameter int N_OUT  = 2,
    parameter int N_PROD = 2,
    parameter int LPP    = 4,
    parameter int ET     = 2,
    parameter int CFG_W  = 2*N_PROD*N_IN + N_PROD*N_OUT + N_OUT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CFG_W-1:0] cfg,
    output logic             busy,
    output logic             done,
    output logic             cfg_err,
    output logic [N_OUT-1:0] max_err,
    output logic [N_IN:0]    err_cnt,
    output logic             pass
);

    localparam int          POL_BASE = N_PROD*N_IN;
    localparam int          ACT_BASE = 2*N_PROD*N_IN;
    localparam int          OEN_BASE = 2*N_PROD*N_IN + N_PROD*N_OUT;
    localparam logic [31:0] ET_C     = 32'(ET);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CHECK = 3'd1,
        S_SWEEP = 3'd2,
        S_DRAIN = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t             state_q;
    logic [CFG_W-1:0]   cfg_q;
    logic [N_IN-1:0]    vec_q;
    logic [N_OUT-1:0]   err_q;
    logic               err_vld_q;
    logic               busy_q;
    logic               done_q;
    logic               cfg_err_q;
    logic [N_OUT-1:0]   max_err_q;
    logic [N_IN:0]      err_cnt_q;
    logic               pass_q;

    logic [N_PROD-1:0]  prod_w;
    logic [N_OUT-1:0]   approx_w;
    logic [N_OUT-1:0]   a_w;
    logic [N_OUT-1:0]   b_w;
    logic [N_OUT-1:0]   exact_w;
    logic [N_OUT-1:0]   err_w;
    logic               lpp_viol_w;
    logic [N_OUT-1:0]   max_err_d;
    logic [N_IN:0]      err_cnt_d;

    function automatic logic lpp_violation(input logic [CFG_W-1:0] c);
        int pop;
        lpp_violation = 1'b0;
        for (int p = 0; p < N_PROD; p++) begin
            pop = 0;
            for (int i = 0; i < N_IN; i++) begin
                pop = pop + int'(c[p*N_IN + i]);
            end
            if (pop > LPP) begin
                lpp_violation = 1'b1;
            end
        end
    endfunction

    // A literal drops its product when the input bit disagrees with the polarity;
    // products with no literals stay at 1.
    always_comb begin
        prod_w = '1;
        for (int p = 0; p < N_PROD; p++) begin
            for (int i = 0; i < N_IN; i++) begin
                if (cfg_q[p*N_IN + i] && (cfg_q[POL_BASE + p*N_IN + i] != vec_q[i])) begin
                    prod_w[p] = 1'b0;
                end
            end
        end
    end

    always_comb begin
        approx_w = '0;
        for (int o = 0; o < N_OUT; o++) begin
            for (int p = 0; p < N_PROD; p++) begin
                if (cfg_q[ACT_BASE + p*N_OUT + o] && prod_w[p]) begin
                    approx_w[o] = 1'b1;
                end
            end
            approx_w[o] = approx_w[o] & cfg_q[OEN_BASE + o];
        end
    end

    assign a_w        = vec_q[N_OUT-1:0];
    assign b_w        = vec_q[N_IN-1:N_OUT];
    assign exact_w    = (a_w >= b_w) ? (a_w - b_w) : (b_w - a_w);
    assign err_w      = (exact_w >= approx_w) ? (exact_w - approx_w) : (approx_w - exact_w);
    assign lpp_viol_w = lpp_violation(cfg_q);

    // Accumulator next-state; pass on the DRAIN edge must see the final error.
    always_comb begin
        max_err_d = max_err_q;
        err_cnt_d = err_cnt_q;
        if (err_vld_q) begin
            if (err_q > max_err_q) begin
                max_err_d = err_q;
            end
            if (err_q != '0) begin
                err_cnt_d = err_cnt_q + (N_IN+1)'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cfg_q     <= '0;
            vec_q     <= '0;
            err_q     <= '0;
            err_vld_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            cfg_err_q <= 1'b0;
            max_err_q <= '0;
            err_cnt_q <= '0;
            pass_q    <= 1'b0;
        end else begin
            done_q    <= 1'b0;
            err_q     <= err_w;
            err_vld_q <= (state_q == S_SWEEP);
            max_err_q <= max_err_d;
            err_cnt_q <= err_cnt_d;

            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        cfg_q     <= cfg;
                        max_err_q <= '0;
                        err_cnt_q <= '0;
                        pass_q    <= 1'b0;
                        cfg_err_q <= 1'b0;
                        busy_q    <= 1'b1;
                        state_q   <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    if (lpp_viol_w) begin
                        cfg_err_q <= 1'b1;
                        pass_q    <= 1'b0;
                        busy_q    <= 1'b0;
                        done_q    <= 1'b1;
                        state_q   <= S_DONE;
                    end else begin
                        vec_q   <= '0;
                        state_q <= S_SWEEP;
                    end
                end
                S_SWEEP: begin
                    vec_q <= vec_q + N_IN'(1);
                    if (vec_q == '1) begin
                        state_q <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    pass_q  <= (32'(max_err_d) <= ET_C) && !cfg_err_q;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                    state_q <= S_DONE;
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign cfg_err = cfg_err_q;
    assign max_err = max_err_q;
    assign err_cnt = err_cnt_q;
    assign pass    = pass_q;

endmodule

`default_nettype wire
